// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs decoded fields, buffers words in a FIFO and streams
// them out with an auto-incrementing byte address. Optional IMM_RANGE_CHECK_EN adds immediate checks.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                opcode,
    input  logic [4:0]                rd,
    input  logic [2:0]                funct3,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    input  logic [6:0]                funct7,
    input  logic [31:0]               immediate,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [ADDR_W-1:0]         out_addr,
    input  logic                      addr_load,
    input  logic [ADDR_W-1:0]         addr_load_val,
    input  logic                      err_clr,
    output logic                      err_illegal,
    output logic                      err_range,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              err_illegal_reg, err_illegal_next;

    logic [31:0] enc_instr;
    logic        enc_legal;
    logic        enc_range_ok;
    logic        xfer, push, pop;

    always_comb begin
        enc_instr = '0;
        enc_legal = 1'b1;
        case (opcode)
            OP_R:
                enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    enc_instr = {funct7, immediate[4:0], rs1, funct3, rd, opcode};
                else
                    enc_instr = {immediate[11:0], rs1, funct3, rd, opcode};
            end
            OP_LOAD, OP_JALR, OP_SYSTEM:
                enc_instr = {immediate[11:0], rs1, funct3, rd, opcode};
            OP_STORE:
                enc_instr = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
            OP_BRANCH:
                enc_instr = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                             immediate[4:1], immediate[11], opcode};
            OP_LUI, OP_AUIPC:
                enc_instr = {immediate[31:12], rd, opcode};
            OP_JAL:
                enc_instr = {immediate[20], immediate[10:1], immediate[11],
                             immediate[19:12], rd, opcode};
            default:
                enc_legal = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A signed N-bit value fits when all bits from N-1 upward agree with the sign.
    logic fit_12, fit_13, fit_21, fit_shamt;
    assign fit_12    = (&immediate[31:11]) | ~(|immediate[31:11]);
    assign fit_13    = ((&immediate[31:12]) | ~(|immediate[31:12])) & ~immediate[0];
    assign fit_21    = ((&immediate[31:20]) | ~(|immediate[31:20])) & ~immediate[0];
    assign fit_shamt = ~(|immediate[31:5]);

    always_comb begin
        enc_range_ok = 1'b1;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    enc_range_ok = fit_shamt;
                else
                    enc_range_ok = fit_12;
            end
            OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE:
                enc_range_ok = fit_12;
            OP_BRANCH:
                enc_range_ok = fit_13;
            OP_LUI, OP_AUIPC:
                enc_range_ok = ~(|immediate[11:0]);
            OP_JAL:
                enc_range_ok = fit_21;
            default:
                enc_range_ok = 1'b1;
        endcase
    end

    logic err_range_reg, err_range_next;
    always_comb begin
        err_range_next = err_range_reg;
        if (err_clr)
            err_range_next = 1'b0;
        if (xfer && enc_legal && !enc_range_ok)
            err_range_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_range_reg <= 1'b0;
        else
            err_range_reg <= err_range_next;
    end
    assign err_range = err_range_reg;
`else
    assign enc_range_ok = 1'b1;
    assign err_range    = 1'b0;
`endif

    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign xfer      = in_valid && in_ready;
    assign push      = xfer && enc_legal && enc_range_ok;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    // Load takes priority over the +4 so a popped word keeps the old address.
    always_comb begin
        addr_next = addr_reg;
        if (addr_load)
            addr_next = {addr_load_val[ADDR_W-1:2], 2'b00};
        else if (pop)
            addr_next = addr_reg + ADDR_W'(4);
    end

    always_comb begin
        err_illegal_next = err_illegal_reg;
        if (err_clr)
            err_illegal_next = 1'b0;
        if (xfer && !enc_legal)
            err_illegal_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            addr_reg        <= BASE_ADDR;
            err_illegal_reg <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            addr_reg        <= addr_next;
            err_illegal_reg <= err_illegal_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && wr_ptr_reg == PW'(gi))
                    mem[gi] <= enc_instr;
            end
        end
    endgenerate

    // Head is masked while empty so stale storage never shows on the port.
    assign out_instr   = out_valid ? mem[rd_ptr_reg] : 32'h0;
    assign out_addr    = addr_reg;
    assign err_illegal = err_illegal_reg;
    assign count       = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder (DEPTH=4, ADDR_W=32, BASE_ADDR=0).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        addr_load;
    logic [31:0] addr_load_val;
    logic        err_clr;
    logic        err_illegal;
    logic        err_range;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .err_clr(err_clr), .err_illegal(err_illegal), .err_range(err_range),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                              input logic [31:0] imm);
        opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; immediate = imm;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                        input logic [31:0] imm);
        set_fields(op, d, f3, s1, s2, f7, imm);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_addr);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_addr"}, out_addr, exp_addr);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    logic [31:0] exp_q [5];
    bit          sent5;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0;
        addr_load_val = '0; err_clr = 1'b0;
        set_fields(7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_errs", {30'b0, err_illegal, err_range}, 32'h0);

        // add x3,x1,x2 visible one cycle after transfer, held while stalled
        send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        check("add_instr", out_instr, 32'h002081B3);
        check("add_addr", out_addr, 32'h0);
        out_ready = 1'b0;
        cyc();
        check("add_hold_instr", out_instr, 32'h002081B3);
        check("add_hold_addr", out_addr, 32'h0);
        pop_check("add", 32'h002081B3, 32'h0);

        send(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
        pop_check("addi_m1", 32'hFFF00293, 32'h4);
        send(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        pop_check("sw", 32'h0020A423, 32'h8);
        send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);
        pop_check("beq", 32'hFE208EE3, 32'hC);
        send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        pop_check("jal", 32'h001000EF, 32'h10);
        // lui x7,0x12345 and slli x6,x1,3 with funct7 0
        send(7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        pop_check("lui", 32'h123453B7, 32'h14);
        send(7'h13, 5'd6, 3'd1, 5'd1, 5'd0, 7'd0, 32'd3);
        pop_check("slli", 32'h00309313, 32'h18);

        send(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
`ifdef IMM_RANGE_CHECK_EN
        check("addi2048_range", {31'b0, err_range}, 32'h1);
        check("addi2048_count", {29'b0, count}, 32'h0);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
`else
        check("addi2048_range", {31'b0, err_range}, 32'h0);
        pop_check("addi2048", 32'h80000293, 32'h1C);
`endif

        // Fill to DEPTH with sink stalled, then drain while the 5th waits
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 5; i++)
            exp_q[i] = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            send(7'h13, 5'(i + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i));
        end
        check("full_in_ready", {31'b0, in_ready}, 32'h0);
        check("full_count", {29'b0, count}, 32'h4);
        set_fields(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4);
        in_valid = 1'b1;
        cyc();
        check("full_blocked_count", {29'b0, count}, 32'h4);
        out_ready = 1'b1;
        sent5 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d_instr", k), out_instr, exp_q[k]);
            check($sformatf("drain%0d_addr", k), out_addr, 32'(4 * k));
            if (in_valid && in_ready) sent5 = 1'b1;
            cyc();
            if (sent5) begin
                in_valid = 1'b0;
                if (k == 1) check("pushpop_count", {29'b0, count}, 32'h3);
            end
        end
        check("drained_count", {29'b0, count}, 32'h0);
        check("drained_valid", {31'b0, out_valid}, 32'h0);
        cyc();
        check("empty_ready_addr", out_addr, 32'h14);
        out_ready = 1'b0;

        // Illegal opcode: no push, sticky flag, clear, and set-beats-clear
        send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0);
        check("illegal_flag", {31'b0, err_illegal}, 32'h1);
        check("illegal_count", {29'b0, count}, 32'h0);
        cyc();
        check("illegal_sticky", {31'b0, err_illegal}, 32'h1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        check("illegal_cleared", {31'b0, err_illegal}, 32'h0);
        err_clr = 1'b1;
        send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0);
        err_clr = 1'b0;
        check("illegal_set_wins", {31'b0, err_illegal}, 32'h1);

        // addr_load concurrent with pop: popped word keeps old address
        send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        send(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
        check("load_pre_addr", out_addr, 32'h14);
        check("load_pre_instr", out_instr, 32'h002081B3);
        out_ready = 1'b1; addr_load = 1'b1; addr_load_val = 32'h103;
        cyc();
        out_ready = 1'b0; addr_load = 1'b0;
        check("load_post_addr", out_addr, 32'h100);
        check("load_post_count", {29'b0, count}, 32'h1);
        pop_check("load_next", 32'hFFF00293, 32'h100);
        check("load_inc_addr", out_addr, 32'h104);

        // Reset mid-stream discards buffered words
        send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        send(7'h33, 5'd4, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("midrst_count", {29'b0, count}, 32'h0);
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_instr", out_instr, 32'h0);
        check("midrst_addr", out_addr, 32'h0);
        check("midrst_err", {31'b0, err_illegal}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the ID-stage field decoder: accepts decoded RV32I fields and packs them into 32-bit instruction words.
- Buffers the packed words in a small FIFO and streams each one out with an auto-incrementing byte address.
- Used by the instruction-memory loader and self-test path to write program images without an external assembler.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 32, width of output byte address
BASE_ADDR, 0, address counter reset value (word aligned)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept tuple
opcode  input  7  opcode field
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  funct7 field (R-type, shift-immediates)
immediate  input  32  signed immediate, byte offset for S/B/J, upper value for U
out_valid  output  1  packed word available
out_ready  input  1  sink accepts word
out_instr  output  32  packed instruction
out_addr  output  ADDR_W  byte address of out_instr
addr_load  input  1  load address counter
addr_load_val  input  ADDR_W  value for addr_load, bits [1:0] ignored (forced 0)
err_clr  input  1  clear sticky error flags
err_illegal  output  1  sticky: unsupported opcode received
err_range  output  1  sticky: immediate out of range (feature only, else tied 0)
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values:
  - FIFO empty; count=0; out_valid=0; out_instr=0.
  - Address counter=BASE_ADDR; err_illegal=0; err_range=0.
  - Reset mid-stream discards all buffered words.
- Input handshake:
  - in_ready = (count != DEPTH); not combinationally dependent on out_ready.
  - Transfer occurs when in_valid && in_ready.
- Encoding (combinational, written into FIFO on the transfer edge). Input-to-out_valid latency is 1 cycle when the FIFO is empty.
  - R (0110011): {funct7,rs2,rs1,funct3,rd,opcode}
  - I (0000011, 0010011, 1100111, 1110011): {imm[11:0],rs1,funct3,rd,opcode}.
  - Exception, 0010011 with funct3 001/101: {funct7,imm[4:0],rs1,funct3,rd,opcode}.
  - S (0100011): {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B (1100011): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U (0110111, 0010111): {imm[31:12],rd,opcode}
  - J (1101111): {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - Unused input fields for a format are ignored.
- Illegal opcode (any other value):
  - Transfer completes.
  - Nothing pushed.
  - err_illegal set next cycle.
- Output:
  - out_valid = (count != 0); out_instr is the FIFO head; out_addr is the address counter.
  - Pop when out_valid && out_ready; the counter then advances by 4 and wraps modulo 2^ADDR_W.
  - out_instr/out_addr must hold stable while out_valid && !out_ready.
- Simultaneous events:
  - Push+pop in one cycle: count unchanged. This is legal only when not full, since in_ready is low when full.
  - addr_load with pop: the popped word uses the old address; counter = addr_load_val next cycle, with no +4.
  - err_clr with a new error event: set wins.
- Empty FIFO: out_ready is ignored, and the counter does not move.
- Pointers: wrap naturally at DEPTH. count is exact 0..DEPTH.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: an immediate that does not fit its format, or a B/J offset that is odd, sets err_range, and the word is dropped (not pushed).
  - Format limits: I/S signed 12-bit; B signed 13-bit even; J signed 21-bit even; shift-immediate 0..31.
  - U immediates with imm[11:0] != 0 also flag.
- Undefined: no checking; bits are truncated per the table above; err_range tied 0.

Test Plan:
- add x3,x1,x2 (op 0x33, rd3, rs1 1, rs2 2, f3 0, f7 0) after reset -> out_instr 0x002081B3, out_addr 0x0 one cycle later; next word at 0x4.
- addi x5,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00293. sw x2,8(x1) -> 0x0020A423.
- beq x1,x2,-4 -> 0xFE208EE3. jal x1,2048 -> 0x001000EF.
- DEPTH=4, out_ready=0, offer 5 tuples -> in_ready low after 4th, count=4. Raise out_ready -> 4 pops at 0x0,0x4,0x8,0xC in order, then 5th accepted.
- opcode 0x7F -> no push, err_illegal=1 until err_clr. addr_load=0x100 concurrent with pop -> popped addr old, next addr 0x100.
- IMM_RANGE_CHECK_EN: addi x5,x0,2048 -> err_range=1, no push. Without macro -> out_instr 0x80000293.
